// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch stage with hold register for decode
// Fetches one word at PC, holds it until decode consumes it, then advances or redirects PC.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_i,
  input  logic        Branch_Taken_i,
  input  logic [31:0] Branch_Target_i,
  output logic        Imem_Req_o,
  output logic [31:0] Imem_Addr_o,
  input  logic        Imem_Ack_i,
  input  logic [31:0] Imem_Data_i,
  output logic        Instr_Valid_o,
  output logic [31:0] Instr_o,
  output logic [6:0]  OP_o,
  output logic [31:0] PC_o,
  output logic [31:0] PC_Plus4_o,
  output logic [31:0] Retired_o,
  output logic        Misalign_o,
  output logic        Timeout_o
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] wait_cnt;
  logic [31:0] wait_inc;
  logic        consume;

  assign consume     = (state == S_HOLD) && !Stall_i;
  assign wait_inc    = (wait_cnt == TIMEOUT_W) ? wait_cnt : wait_cnt + 32'd1;
  assign Imem_Addr_o = pc;
  assign PC_o        = pc;
  assign PC_Plus4_o  = pc + 32'd4;
  assign OP_o        = Instr_o[6:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_REQ;
      S_REQ:   if (Imem_Ack_i) state_next = S_HOLD;
      S_HOLD:  if (!Stall_i) state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Imem_Req_o    = 1'b0;
    Instr_Valid_o = 1'b0;
    case (state)
      S_REQ:   Imem_Req_o    = 1'b1;
      S_HOLD:  Instr_Valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      Instr_o    <= NOP;
      Retired_o  <= 32'd0;
      wait_cnt   <= 32'd0;
      Misalign_o <= 1'b0;
      Timeout_o  <= 1'b0;
    end else begin
      if (state == S_REQ && Imem_Ack_i) begin
        Instr_o <= Imem_Data_i;
      end
      if (consume) begin
        pc        <= Branch_Taken_i ? {Branch_Target_i[31:2], 2'b00} : pc + 32'd4;
        Retired_o <= Retired_o + 32'd1;
        if (Branch_Taken_i && (Branch_Target_i[1:0] != 2'b00)) begin
          Misalign_o <= 1'b1;
        end
      end
      // Counter idles at zero outside REQ, so every entry to REQ starts a fresh count.
      if (state != S_REQ) begin
        wait_cnt <= 32'd0;
      end else if (!Imem_Ack_i) begin
        wait_cnt <= wait_inc;
        if (wait_inc == TIMEOUT_W) begin
          Timeout_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized and directed checks of instruction_fetch against a behavioural model
module tb_instruction_fetch;

  localparam logic [31:0] RPC_A = 32'h0040_0000;
  localparam int          TMO_A = 255;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFFC;
  localparam int          TMO_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, br_taken, ack;
  logic [31:0] br_tgt, data;

  logic        req_a, valid_a, mis_a, tmo_a;
  logic [31:0] addr_a, instr_a, pc_a, pc4_a, ret_a;
  logic [6:0]  op_a;
  logic        req_b, valid_b, mis_b, tmo_b;
  logic [31:0] addr_b, instr_b, pc_b, pc4_b, ret_b;
  logic [6:0]  op_b;

  instruction_fetch #(.RESET_PC(RPC_A), .TIMEOUT(TMO_A)) dut_a (
    .clk(clk), .reset(reset), .Stall_i(stall), .Branch_Taken_i(br_taken),
    .Branch_Target_i(br_tgt), .Imem_Req_o(req_a), .Imem_Addr_o(addr_a),
    .Imem_Ack_i(ack), .Imem_Data_i(data), .Instr_Valid_o(valid_a),
    .Instr_o(instr_a), .OP_o(op_a), .PC_o(pc_a), .PC_Plus4_o(pc4_a),
    .Retired_o(ret_a), .Misalign_o(mis_a), .Timeout_o(tmo_a)
  );

  instruction_fetch #(.RESET_PC(RPC_B), .TIMEOUT(TMO_B)) dut_b (
    .clk(clk), .reset(reset), .Stall_i(stall), .Branch_Taken_i(br_taken),
    .Branch_Target_i(br_tgt), .Imem_Req_o(req_b), .Imem_Addr_o(addr_b),
    .Imem_Ack_i(ack), .Imem_Data_i(data), .Instr_Valid_o(valid_b),
    .Instr_o(instr_b), .OP_o(op_b), .PC_o(pc_b), .PC_Plus4_o(pc4_b),
    .Retired_o(ret_b), .Misalign_o(mis_b), .Timeout_o(tmo_b)
  );

  // phase: 0 = dead cycle after reset, 1 = waiting on memory, 2 = holding an instruction
  typedef struct {
    int          phase;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
    int          waited;
    bit          mis;
    bit          tmo;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input logic rst_n, input logic stl,
                                input logic br, input logic [31:0] tgt, input logic ak,
                                input logic [31:0] dat, input logic [31:0] rpc, input int lim);
    mdl_t n;
    n = m;
    if (rst_n !== 1'b1) begin
      n.phase = 0; n.pc = rpc; n.instr = 32'h13; n.retired = 0;
      n.waited = 0; n.mis = 0; n.tmo = 0;
      return n;
    end
    if (m.phase == 0) begin
      n.phase = 1;
      n.waited = 0;
    end else if (m.phase == 1) begin
      if (ak) begin
        n.instr = dat;
        n.phase = 2;
      end else begin
        if (n.waited < lim) n.waited = n.waited + 1;
        if (n.waited >= lim) n.tmo = 1;
      end
    end else if (!stl) begin
      n.pc = br ? (tgt & 32'hFFFF_FFFC) : m.pc + 32'd4;
      n.retired = m.retired + 32'd1;
      if (br && (tgt % 4 != 0)) n.mis = 1;
      n.phase = 1;
      n.waited = 0;
    end
    return n;
  endfunction

  mdl_t ma, mb;
  bit   started = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    ma <= step(ma, reset, stall, br_taken, br_tgt, ack, data, RPC_A, TMO_A);
    mb <= step(mb, reset, stall, br_taken, br_tgt, ack, data, RPC_B, TMO_B);
    if (reset === 1'b0) started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a_req",   req_a,   ma.phase == 1);
      chk("a_valid", valid_a, ma.phase == 2);
      chk("a_addr",  addr_a,  ma.pc);
      chk("a_instr", instr_a, ma.instr);
      chk("a_op",    op_a,    ma.instr & 32'h7F);
      chk("a_pc",    pc_a,    ma.pc);
      chk("a_pc4",   pc4_a,   ma.pc + 32'd4);
      chk("a_ret",   ret_a,   ma.retired);
      chk("a_mis",   mis_a,   ma.mis);
      chk("a_tmo",   tmo_a,   ma.tmo);
      chk("b_req",   req_b,   mb.phase == 1);
      chk("b_valid", valid_b, mb.phase == 2);
      chk("b_addr",  addr_b,  mb.pc);
      chk("b_instr", instr_b, mb.instr);
      chk("b_op",    op_b,    mb.instr & 32'h7F);
      chk("b_pc4",   pc4_b,   mb.pc + 32'd4);
      chk("b_ret",   ret_b,   mb.retired);
      chk("b_mis",   mis_b,   mb.mis);
      chk("b_tmo",   tmo_b,   mb.tmo);
    end
  end

  int ack_pct;

  initial begin
    reset = 1'b0; stall = 1'b1; br_taken = 1'b0; br_tgt = '0; ack = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    chk("rst_instr", instr_a, 32'h0000_0013);
    chk("rst_valid", valid_a, 0);
    chk("rst_req",   req_a,   0);
    chk("rst_pc",    pc_a,    32'h0040_0000);
    chk("rst_ret",   ret_a,   0);

    reset = 1'b1; ack = 1'b1; data = 32'h0000_0033;
    @(negedge clk);
    chk("first_req",  req_a,  1);
    chk("first_addr", addr_a, 32'h0040_0000);
    @(negedge clk);
    chk("first_valid", valid_a, 1);
    chk("first_op",    op_a,    7'h33);
    chk("first_pc4",   pc4_a,   32'h0040_0004);
    chk("wrap_pc4",    pc4_b,   32'h0000_0000);
    ack = 1'b0; stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_req", req_a, 0);
      chk("stall_ret", ret_a, 0);
      chk("stall_instr", instr_a, 32'h0000_0033);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("next_addr",   addr_a, 32'h0040_0004);
    chk("next_ret",    ret_a,  1);
    chk("wrap_addr",   addr_b, 32'h0000_0000);
    chk("wrap_ret",    ret_b,  1);
    stall = 1'b1; ack = 1'b1; data = 32'h0000_0063;
    @(negedge clk);
    ack = 1'b0; stall = 1'b0; br_taken = 1'b1; br_tgt = 32'h0040_0102;
    @(negedge clk);
    chk("br_addr", addr_a, 32'h0040_0100);
    chk("br_mis",  mis_a,  1);
    br_taken = 1'b0; br_tgt = 32'h1234_5679;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 254) chk("tmo_before", tmo_a, 0);
      if (i == 255) chk("tmo_at",     tmo_a, 1);
      if (addr_a !== 32'h0040_0100) chk("tmo_addr", addr_a, 32'h0040_0100);
    end
    ack = 1'b1; data = 32'h0000_00B3;
    @(negedge clk);
    chk("late_valid", valid_a, 1);
    chk("late_tmo",   tmo_a,   1);
    ack = 1'b0; stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; ack = 1'b1; data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abandon_instr", instr_a, 32'h0000_0013);
    chk("abandon_req",   req_a,   1);
    chk("abandon_addr",  addr_a,  32'h0040_0000);
    chk("abandon_mis",   mis_a,   0);
    chk("abandon_tmo",   tmo_a,   0);
    ack = 1'b0;

    ack_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 64 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 95);
      reset    = ($urandom_range(0, 199) != 0);
      stall    = ($urandom_range(0, 2) == 0);
      br_taken = ($urandom_range(0, 3) == 0);
      br_tgt   = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      ack      = ($urandom_range(0, 99) < ack_pct);
      data     = $urandom;
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL give the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 255, SHALL give the maximum wait cycles for Imem_Ack_i before Timeout_o is set.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-low reset.
REQ-005 Stall_i  in  1  SHALL mean that decode cannot accept the held instruction this cycle.
REQ-006 Branch_Taken_i  in  1  SHALL mean that the held instruction redirects the PC.
REQ-007 Branch_Target_i  in  32  SHALL carry the redirect address.
REQ-008 Imem_Req_o  out  1  SHALL be the instruction memory read request.
REQ-009 Imem_Addr_o  out  32  SHALL be the instruction memory word address.
REQ-010 Imem_Ack_i  in  1  SHALL mean that Imem_Data_i is valid this cycle.
REQ-011 Imem_Data_i  in  32  SHALL carry the instruction memory read data.
REQ-012 Instr_Valid_o  out  1  SHALL mean that Instr_o, OP_o, PC_o and PC_Plus4_o describe a valid held instruction.
REQ-013 Instr_o  out  32  SHALL be the held instruction word.
REQ-014 OP_o  out  7  SHALL equal Instr_o[6:0] and feed the control unit opcode input.
REQ-015 PC_o / PC_Plus4_o  out  32 each  SHALL be the held instruction's address and that address + 4.
REQ-016 Retired_o  out  32  SHALL count consumed instructions.
REQ-017 Misalign_o / Timeout_o  out  1 each  SHALL be sticky error flags.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ and HOLD.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-020 In REQ: Imem_Req_o=1 and Imem_Addr_o=PC; the address SHALL stay stable until the ack.
REQ-021 In REQ, an ack SHALL capture Imem_Data_i into Instr_o and move the FSM to HOLD.
REQ-022 Instr_Valid_o SHALL be 1 exactly while the FSM is in HOLD; Imem_Req_o SHALL be 0 in IDLE and HOLD.
REQ-023 Consume SHALL be defined as HOLD & ~Stall_i.
REQ-024 On consume: PC <= Branch_Taken_i ? {Branch_Target_i[31:2],2'b00} : PC+4; Retired_o += 1; FSM -> REQ.
REQ-025 While in HOLD with Stall_i=1, Instr_o, PC_o and Instr_Valid_o SHALL hold unchanged.
REQ-026 Branch_Taken_i and Branch_Target_i SHALL be ignored except in a consume cycle.
REQ-027 If a taken branch has a target with bits [1:0] != 0, Misalign_o SHALL be set to 1; the redirect still proceeds with those bits cleared.
REQ-028 Imem_Ack_i SHALL be ignored outside REQ.
REQ-029 With a zero-wait memory (ack in the REQ cycle), Instr_Valid_o SHALL rise the next cycle, giving a throughput of one instruction per 2 cycles.
REQ-030 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-031 When the wait counter reaches TIMEOUT, Timeout_o SHALL be set; the FSM SHALL remain in REQ, and the counter SHALL saturate.
REQ-032 PC+4 and Retired_o SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-033 PC_Plus4_o SHALL be combinational PC_o + 4, with the same wrap as REQ-032.

Reset
REQ-034 On a clock edge with reset=0, the block SHALL load: FSM=IDLE, PC=RESET_PC, Instr_o=32'h0000_0013 (NOP), Instr_Valid_o=0, Imem_Req_o=0, Retired_o=0, wait counter=0, Misalign_o=0, Timeout_o=0.
REQ-035 Reset asserted in any state, including mid-REQ, SHALL abandon the pending fetch; a late ack arriving after reset SHALL be ignored until the new REQ state.
REQ-036 Misalign_o and Timeout_o SHALL clear only on reset.

Verification
REQ-037 Reset release with zero-wait memory returning 32'h0000_0033: Req high in cycle 2 at 0x0040_0000; cycle 3 shows Instr_Valid_o=1, OP_o=7'h33, PC_Plus4_o=0x0040_0004.
REQ-038 Stall_i=1 for 5 cycles in HOLD: outputs stable, no request issued, Retired_o unchanged; Stall_i=0 -> next request goes to 0x0040_0004.
REQ-039 Taken branch on consume to 0x0040_0102: next Imem_Addr_o=0x0040_0100 and Misalign_o=1.
REQ-040 Ack withheld for 300 cycles: Timeout_o=1 at wait count 255, Imem_Addr_o stable throughout; ack at cycle 300 -> HOLD.
REQ-041 RESET_PC=32'hFFFF_FFFC, one consume: next address 32'h0000_0000, Retired_o=1.
REQ-042 reset=0 during REQ, then ack arrives in IDLE: ack ignored, Instr_o=32'h0000_0013, next request at RESET_PC.
